// File: rtl/aib_sr_pkg.sv
// Shared types and constants for the AIB sideband shift-register engine.
package aib_sr_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_LOAD  = 2'd2,
    TX_GAP   = 2'd3
  } tx_state_e;

  localparam int unsigned SR_LENGTH_MIN   = 8;
  localparam int unsigned SR_LENGTH_MAX   = 127;
  localparam int unsigned GAP_CYCLES_MAX  = 15;
  localparam int unsigned MATCH_COUNT_MIN = 1;
  localparam int unsigned MATCH_COUNT_MAX = 7;
  localparam int unsigned MATCH_CNT_W     = 3;
  localparam int unsigned GAP_CNT_W       = 4;

  // Bit/frame counter width: must hold 0..SR_LENGTH+1 (RX saturation point).
  function automatic int unsigned SR_CNT_W(input int unsigned len);
    return $clog2(len + 2);
  endfunction

endpackage

// File: rtl/aib_sr_rx_filter.sv
// Receive side: frame-length check, N-consecutive-match filter and the
// core-facing received-word register.
module aib_sr_rx_filter
  import aib_sr_pkg::*;
#(
  parameter int unsigned         SR_LENGTH   = 81,
  parameter int unsigned         MATCH_COUNT = 2,
  parameter logic [SR_LENGTH-1:0] RESET_VALUE = '0
) (
  input  logic                 osc_clk,
  input  logic                 reset_n,
  input  logic                 sr_data_in,
  input  logic                 sr_load_in,
  output logic [SR_LENGTH-1:0] sr_data_to_core,
  output logic                 rx_frame_valid,
  output logic                 rx_frame_err
);

  localparam int unsigned CW = SR_CNT_W(SR_LENGTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(SR_LENGTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(SR_LENGTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [MATCH_CNT_W-1:0] MATCH_MAX = MATCH_CNT_W'(MATCH_COUNT);
  localparam logic [MATCH_CNT_W-1:0] MATCH_ONE = MATCH_CNT_W'(1);

  logic [SR_LENGTH-1:0]   rx_shift_q, rx_shift_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [SR_LENGTH-1:0]   cand_q, cand_d;
  logic [MATCH_CNT_W-1:0] match_q, match_d;
  logic [SR_LENGTH-1:0]   core_q, core_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  // Next-state: shift/count on data cycles, qualify and filter on load cycles.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    cand_d     = cand_q;
    match_d    = match_q;
    core_d     = core_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (!sr_load_in) begin
      rx_shift_d = {rx_shift_q[SR_LENGTH-2:0], sr_data_in};
      if (rx_cnt_q != CNT_SAT) rx_cnt_d = rx_cnt_q + CNT_ONE;
    end else begin
      rx_cnt_d = '0;
      if (rx_cnt_q != CNT_FULL) begin
        err_d   = 1'b1;
        match_d = '0;
      end else begin
        if ((match_q != '0) && (rx_shift_q == cand_q)) begin
          if (match_q != MATCH_MAX) match_d = match_q + MATCH_ONE;
        end else begin
          cand_d  = rx_shift_q;
          match_d = MATCH_ONE;
        end
        if ((match_d == MATCH_MAX) && (cand_d != core_q)) begin
          core_d  = cand_d;
          valid_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge osc_clk) begin
    if (!reset_n) begin
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      cand_q     <= '0;
      match_q    <= '0;
      core_q     <= RESET_VALUE;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      cand_q     <= cand_d;
      match_q    <= match_d;
      core_q     <= core_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign sr_data_to_core = core_q;
  assign rx_frame_valid  = valid_q;
  assign rx_frame_err    = err_q;

endmodule

// File: rtl/aib_sr_engine.sv
// Parametrised AIB sideband shift-register engine: serialises the core
// control word onto std/stl and filters frames received from srd/srl.
module aib_sr_engine
  import aib_sr_pkg::*;
#(
  parameter int unsigned          SR_LENGTH   = 81,
  parameter int unsigned          GAP_CYCLES  = 2,
  parameter int unsigned          MATCH_COUNT = 2,
  parameter logic [SR_LENGTH-1:0] RESET_VALUE = '0
) (
  input  logic                 osc_clk,
  input  logic                 reset_n,
  input  logic                 sr_en,
  input  logic [SR_LENGTH-1:0] sr_data_fr_core,
  output logic                 sr_data_out,
  output logic                 sr_load_out,
  input  logic                 sr_data_in,
  input  logic                 sr_load_in,
  output logic [SR_LENGTH-1:0] sr_data_to_core,
  output logic                 tx_frame_done,
  output logic                 rx_frame_valid,
  output logic                 rx_frame_err
);

  localparam int unsigned CW = SR_CNT_W(SR_LENGTH);
  localparam logic [CW-1:0]        BIT_LAST = CW'(SR_LENGTH - 1);
  localparam logic [CW-1:0]        BIT_ONE  = CW'(1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);

  tx_state_e              state_q, state_d;
  logic [SR_LENGTH-1:0]   tx_shift_q, tx_shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   frame_boundary;

  // TX next-state and pad outputs. IDLE, the end of GAP, and LOAD when there
  // is no gap all share one frame-boundary decision: relatch or go idle.
  always_comb begin
    state_d        = state_q;
    tx_shift_d     = tx_shift_q;
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    sr_data_out    = 1'b0;
    sr_load_out    = 1'b0;
    tx_frame_done  = 1'b0;
    frame_boundary = 1'b0;
    case (state_q)
      TX_IDLE: frame_boundary = 1'b1;
      TX_SHIFT: begin
        sr_data_out = tx_shift_q[SR_LENGTH-1];
        tx_shift_d  = tx_shift_q << 1;
        bit_cnt_d   = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == BIT_LAST) state_d = TX_LOAD;
      end
      TX_LOAD: begin
        sr_load_out   = 1'b1;
        tx_frame_done = 1'b1;
        if (GAP_CYCLES == 0) begin
          frame_boundary = 1'b1;
        end else begin
          gap_cnt_d = '0;
          state_d   = TX_GAP;
        end
      end
      TX_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_ONE;
        if (gap_cnt_q == GAP_LAST) frame_boundary = 1'b1;
      end
    endcase
    if (frame_boundary) begin
      if (sr_en) begin
        tx_shift_d = sr_data_fr_core;
        bit_cnt_d  = '0;
        state_d    = TX_SHIFT;
      end else begin
        state_d = TX_IDLE;
      end
    end
  end

  // TX state registers with synchronous active-low reset.
  always_ff @(posedge osc_clk) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      tx_shift_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  aib_sr_rx_filter #(
    .SR_LENGTH   (SR_LENGTH),
    .MATCH_COUNT (MATCH_COUNT),
    .RESET_VALUE (RESET_VALUE)
  ) u_rx_filter (
    .osc_clk         (osc_clk),
    .reset_n         (reset_n),
    .sr_data_in      (sr_data_in),
    .sr_load_in      (sr_load_in),
    .sr_data_to_core (sr_data_to_core),
    .rx_frame_valid  (rx_frame_valid),
    .rx_frame_err    (rx_frame_err)
  );

endmodule

// File: tb/tb_aib_sr_engine.sv
// Directed bench for aib_sr_engine (SR_LENGTH=81, GAP_CYCLES=2, MATCH_COUNT=2).
module tb_aib_sr_engine;

  localparam logic [80:0] WA = 81'h1_2345_6789_ABCD_EF01_2345;
  localparam logic [80:0] WB = 81'h0_FEDC_BA98_7654_3210_FEDC;
  localparam logic [80:0] WC = 81'h1_5555_AAAA_5555_AAAA_5555;

  logic        osc_clk = 1'b0;
  logic        reset_n;
  logic        sr_en;
  logic [80:0] sr_data_fr_core;
  logic        sr_data_out;
  logic        sr_load_out;
  logic        sr_data_in;
  logic        sr_load_in;
  logic [80:0] sr_data_to_core;
  logic        tx_frame_done;
  logic        rx_frame_valid;
  logic        rx_frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 osc_clk = ~osc_clk;

  aib_sr_engine #(
    .SR_LENGTH   (81),
    .GAP_CYCLES  (2),
    .MATCH_COUNT (2),
    .RESET_VALUE (81'h0)
  ) dut (
    .osc_clk         (osc_clk),
    .reset_n         (reset_n),
    .sr_en           (sr_en),
    .sr_data_fr_core (sr_data_fr_core),
    .sr_data_out     (sr_data_out),
    .sr_load_out     (sr_load_out),
    .sr_data_in      (sr_data_in),
    .sr_load_in      (sr_load_in),
    .sr_data_to_core (sr_data_to_core),
    .tx_frame_done   (tx_frame_done),
    .rx_frame_valid  (rx_frame_valid),
    .rx_frame_err    (rx_frame_err)
  );

  typedef struct {
    int unsigned nbits;
    logic [80:0] word;
    logic        exp_err;
    logic        exp_valid;
    logic [80:0] exp_core;
  } rx_vec_t;

  rx_vec_t vecs[17];

  task automatic tick();
    @(posedge osc_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shift n bits (low n bits of w, MSB first; zeros above bit 80), then one load cycle.
  task automatic send_rx_frame(input logic [80:0] w, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      sr_load_in = 1'b0;
      sr_data_in = (i < 81) ? w[i] : 1'b0;
      tick();
      if (i == int'(n) - 1) chk("rx_pulse_clear", {rx_frame_err, rx_frame_valid}, 2'b00);
    end
    sr_load_in = 1'b1;
    sr_data_in = 1'b1;
    tick();
    sr_load_in = 1'b0;
    sr_data_in = 1'b0;
  endtask

  // Entered with the first bit of w already on sr_data_out.
  // action 1: change sr_data_fr_core to WB at bit 40; action 2: drop sr_en at bit 40.
  task automatic tx_frame(input logic [80:0] w, input int unsigned action, output int load_cyc);
    for (int i = 0; i < 81; i++) begin
      chk("tx_bit", {sr_load_out, tx_frame_done, sr_data_out}, {2'b00, w[80-i]});
      if (i == 40) begin
        if (action == 1) sr_data_fr_core = WB;
        else if (action == 2) sr_en = 1'b0;
      end
      tick();
    end
    chk("tx_load", {sr_load_out, tx_frame_done, sr_data_out}, 3'b110);
    load_cyc = cyc;
    tick();
    chk("tx_gap0", {sr_load_out, tx_frame_done, sr_data_out}, 3'b000);
    tick();
    chk("tx_gap1", {sr_load_out, tx_frame_done, sr_data_out}, 3'b000);
  endtask

  initial begin
    int c0, l1, l2, bad;
    logic err_seen;

    vecs[0]  = '{81, WA, 1'b0, 1'b0, 81'h0};
    vecs[1]  = '{81, WA, 1'b0, 1'b1, WA};
    vecs[2]  = '{81, WA, 1'b0, 1'b0, WA};
    vecs[3]  = '{81, WB, 1'b0, 1'b0, WA};
    vecs[4]  = '{80, WC, 1'b1, 1'b0, WA};
    vecs[5]  = '{81, WB, 1'b0, 1'b0, WA};
    vecs[6]  = '{81, WB, 1'b0, 1'b1, WB};
    vecs[7]  = '{81, WC, 1'b0, 1'b0, WB};
    vecs[8]  = '{81, WA, 1'b0, 1'b0, WB};
    vecs[9]  = '{81, WC, 1'b0, 1'b0, WB};
    vecs[10] = '{81, WA, 1'b0, 1'b0, WB};
    vecs[11] = '{81, WA, 1'b0, 1'b1, WA};
    vecs[12] = '{82, WA, 1'b1, 1'b0, WA};
    vecs[13] = '{0,  WA, 1'b1, 1'b0, WA};
    vecs[14] = '{81, WC, 1'b0, 1'b0, WA};
    vecs[15] = '{81, WC, 1'b0, 1'b1, WC};
    vecs[16] = '{81, WC, 1'b0, 1'b0, WC};

    reset_n         = 1'b0;
    sr_en           = 1'b0;
    sr_data_fr_core = '0;
    sr_data_in      = 1'b0;
    sr_load_in      = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {sr_data_out, sr_load_out, tx_frame_done, rx_frame_valid, rx_frame_err}, 5'b0);
    chk("reset_to_core", sr_data_to_core, 81'h0);

    // RX table: length check, match filtering, alternation, repeats.
    reset_n = 1'b1;
    for (int v = 0; v < 17; v++) begin
      send_rx_frame(vecs[v].word, vecs[v].nbits);
      chk("rx_err", rx_frame_err, vecs[v].exp_err);
      chk("rx_valid", rx_frame_valid, vecs[v].exp_valid);
      chk("rx_to_core", sr_data_to_core, vecs[v].exp_core);
    end
    chk("tx_quiet_while_disabled", {sr_data_out, sr_load_out, tx_frame_done}, 3'b000);

    // TX: two frames, mid-frame word change ignored, then sr_en dropped mid-frame.
    sr_data_fr_core = WA;
    sr_en = 1'b1;
    tick();
    c0 = cyc;
    tx_frame(WA, 1, l1);
    chk("tx_load_offset", 81'(l1 - c0), 81'd81);
    tick();
    tx_frame(WB, 2, l2);
    chk("tx_period", 81'(l2 - l1), 81'd84);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sr_data_out || sr_load_out || tx_frame_done) bad++;
    end
    chk("tx_idle_after_drop", 81'(bad), 81'd0);

    // Reset at bit 50 of simultaneous TX and RX frames, then clean resume.
    sr_data_fr_core = WB;
    sr_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sr_data_in = WA[80-i];
      tick();
    end
    reset_n = 1'b0;
    tick();
    chk("midframe_reset_outputs", {sr_data_out, sr_load_out, tx_frame_done, rx_frame_valid, rx_frame_err}, 5'b0);
    chk("midframe_reset_to_core", sr_data_to_core, 81'h0);
    reset_n = 1'b1;
    err_seen = 1'b0;
    for (int i = 0; i < 81; i++) begin
      sr_load_in = 1'b0;
      sr_data_in = WA[80-i];
      tick();
      chk("resume_tx_bit", {sr_load_out, sr_data_out}, {1'b0, WB[80-i]});
      err_seen = err_seen | rx_frame_err | rx_frame_valid;
    end
    sr_load_in = 1'b1;
    tick();
    sr_load_in = 1'b0;
    sr_data_in = 1'b0;
    chk("resume_tx_load", {sr_load_out, tx_frame_done}, 2'b11);
    chk("resume_rx_first", {rx_frame_err, rx_frame_valid}, 2'b00);
    chk("resume_to_core_held", sr_data_to_core, 81'h0);
    chk("resume_no_spurious", err_seen, 1'b0);
    send_rx_frame(WA, 81);
    chk("resume_rx_second", {rx_frame_err, rx_frame_valid}, 2'b01);
    chk("resume_to_core", sr_data_to_core, WA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
